wallace_cpa: RTL and testbench

Pipelined carry-propagate adder that sits directly downstream of the Wallace-tree compressor in the multiplier datapath. It takes the redundant sum/carry pair from the tree and resolves it into a single binary result, modulo 2^DW. The addition is split into two registered stages at bit SPLIT, and a valid/ready handshake provides full-throughput back-pressure.

---
 rtl/wallace_cpa.sv | 98 +++++++++
 tb/tb_wallace_cpa.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_cpa.sv
// Two-stage pipelined carry-propagate adder resolving the Wallace-tree sum/carry pair.
// Optional registered zero flag on result_o when WALLACE_CPA_ZERO_FLAG_EN is defined.
module wallace_cpa #(
    parameter int unsigned DW    = 16,
    parameter int unsigned SPLIT = DW / 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] sum_i,
    input  logic [DW-1:0] carry_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] result_o
`ifdef WALLACE_CPA_ZERO_FLAG_EN
    ,
    output logic          zero_o
`endif
);

    localparam int unsigned HW = DW - SPLIT;

    logic             r_s1_valid;
    logic [SPLIT-1:0] r_s1_lo;
    logic             r_s1_c1;
    logic [HW-1:0]    r_s1_sum_hi;
    logic [HW-1:0]    r_s1_carry_hi;
    logic             r_s2_valid;
    logic [DW-1:0]    r_s2_result;

    logic             w_en1;
    logic             w_en2;
    logic [SPLIT:0]   w_lo_sum;
    logic [HW-1:0]    w_hi;
    logic [DW-1:0]    w_result;

    // Stage enables and the two half-width adders.
    always_comb begin
        w_en2    = !r_s2_valid || ready_i;
        w_en1    = !r_s1_valid || w_en2;
        w_lo_sum = {1'b0, sum_i[SPLIT-1:0]} + {1'b0, carry_i[SPLIT-1:0]};
        w_hi     = r_s1_sum_hi + r_s1_carry_hi + HW'(r_s1_c1);
        w_result = {w_hi, r_s1_lo};
    end

    // Stage 1: resolve the low half, keep the raw high halves.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s1_valid    <= 1'b0;
            r_s1_lo       <= '0;
            r_s1_c1       <= 1'b0;
            r_s1_sum_hi   <= '0;
            r_s1_carry_hi <= '0;
        end else if (w_en1) begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_s1_lo       <= w_lo_sum[SPLIT-1:0];
                r_s1_c1       <= w_lo_sum[SPLIT];
                r_s1_sum_hi   <= sum_i[DW-1:SPLIT];
                r_s1_carry_hi <= carry_i[DW-1:SPLIT];
            end
        end
    end

    // Stage 2: high half plus low carry; final carry-out is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
        end else if (w_en2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_result;
            end
        end
    end

`ifdef WALLACE_CPA_ZERO_FLAG_EN
    logic r_s2_zero;

    // Reset value is 1 because the reset result is 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s2_zero <= 1'b1;
        end else if (w_en2 && r_s1_valid) begin
            r_s2_zero <= (w_result == '0);
        end
    end

    assign zero_o = r_s2_zero;
`endif

    assign ready_o  = w_en1;
    assign valid_o  = r_s2_valid;
    assign result_o = r_s2_result;

endmodule

// File: tb/tb_wallace_cpa.sv
// Bench for wallace_cpa: three instances (SPLIT = 1, 8, 15) share one stimulus stream
// and are checked against a capacity-2, latency-2 FIFO model of (a+b) mod 2^16.
module tb_wallace_cpa;

    localparam int unsigned DW = 16;
    localparam int unsigned NI = 3;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] sum_in;
    logic [DW-1:0] carry_in;

    logic          w_ready [NI];
    logic          w_valid [NI];
    logic [DW-1:0] w_res   [NI];
`ifdef WALLACE_CPA_ZERO_FLAG_EN
    logic          w_zero  [NI];
`endif

    int n_chk;
    int n_err;
    int n_acc;
    int n_out;
    int n_drop;

    logic [DW-1:0] q_val [$];
    int            q_age [$];
    logic [DW-1:0] out_log [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wallace_cpa #(
            .DW   (DW),
            .SPLIT((g == 0) ? 1 : ((g == 1) ? 8 : 15))
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (valid_in),
            .ready_o (w_ready[g]),
            .sum_i   (sum_in),
            .carry_i (carry_in),
            .valid_o (w_valid[g]),
            .ready_i (ready_in),
            .result_o(w_res[g])
`ifdef WALLACE_CPA_ZERO_FLAG_EN
            ,
            .zero_o  (w_zero[g])
`endif
        );
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[split#%0d] @%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // One clock: compare against the model at negedge, advance the model at posedge.
    task automatic tick();
        logic exp_rdy;
        logic exp_vld;
        @(negedge clk);
        exp_rdy = (q_val.size() < 2) || ready_in;
        exp_vld = (q_val.size() > 0) && (q_age[0] >= 2);
        for (int i = 0; i < NI; i++) begin
            chk("ready_o", i, 32'(w_ready[i]), 32'(exp_rdy));
            chk("valid_o", i, 32'(w_valid[i]), 32'(exp_vld));
            if (exp_vld) begin
                chk("result_o", i, 32'(w_res[i]), 32'(q_val[0]));
`ifdef WALLACE_CPA_ZERO_FLAG_EN
                chk("zero_o", i, 32'(w_zero[i]), 32'(q_val[0] == '0));
`endif
            end
        end
        if (w_valid[0] && ready_in) begin
            out_log.push_back(w_res[0]);
            n_out++;
        end
        @(posedge clk);
        if (!rst_n) begin
            n_drop += q_val.size();
            q_val.delete();
            q_age.delete();
        end else begin
            if (exp_vld && ready_in) begin
                void'(q_val.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[k]) q_age[k]++;
            if (valid_in && exp_rdy) begin
                q_val.push_back(DW'(sum_in + carry_in));
                q_age.push_back(1);
                n_acc++;
            end
        end
        #1;
    endtask

    vec_t tbl [10];
    int   snap;
    int   cyc;
    int   acc0;

    initial begin
        n_chk = 0; n_err = 0; n_acc = 0; n_out = 0; n_drop = 0;
        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; sum_in = '0; carry_in = '0;

        tbl[0] = '{16'h00FF, 16'h0001, 16'h0100};
        tbl[1] = '{16'hFFFF, 16'h0001, 16'h0000};
        tbl[2] = '{16'h1234, 16'h4321, 16'h5555};
        tbl[3] = '{16'h8000, 16'h8000, 16'h0000};
        tbl[4] = '{16'h7FFF, 16'h0001, 16'h8000};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};
        tbl[6] = '{16'h0001, 16'h0001, 16'h0002};
        tbl[7] = '{16'h0080, 16'h0080, 16'h0100};
        tbl[8] = '{16'h4000, 16'hC000, 16'h0000};
        tbl[9] = '{16'hABCD, 16'h0000, 16'hABCD};

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid_o", i, 32'(w_valid[i]), 32'd0);
            chk("rst_result_o", i, 32'(w_res[i]), 32'd0);
            chk("rst_ready_o", i, 32'(w_ready[i]), 32'd1);
`ifdef WALLACE_CPA_ZERO_FLAG_EN
            chk("rst_zero_o", i, 32'(w_zero[i]), 32'd1);
`endif
        end
        rst_n = 1'b1;

        // Directed vectors with exact two-cycle latency.
        for (int v = 0; v < 10; v++) begin
            ready_in = 1'b1; valid_in = 1'b1;
            sum_in = tbl[v].a; carry_in = tbl[v].b;
            tick();
            valid_in = 1'b0;
            for (int i = 0; i < NI; i++) chk("lat1_valid_o", i, 32'(w_valid[i]), 32'd0);
            tick();
            for (int i = 0; i < NI; i++) begin
                chk("lat2_valid_o", i, 32'(w_valid[i]), 32'd1);
                chk("vec_result_o", i, 32'(w_res[i]), 32'(tbl[v].exp));
`ifdef WALLACE_CPA_ZERO_FLAG_EN
                chk("vec_zero_o", i, 32'(w_zero[i]), 32'(tbl[v].exp == '0));
`endif
            end
            tick();
        end

        // Back-pressure: two buffered, third held, in-order release.
        out_log.delete();
        ready_in = 1'b0; valid_in = 1'b1; carry_in = '0;
        sum_in = 16'h0001; tick();
        sum_in = 16'h0002; tick();
        sum_in = 16'h0003;
        for (int i = 0; i < NI; i++) chk("bp_ready_o", i, 32'(w_ready[i]), 32'd0);
        tick(); tick();
        ready_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick(); tick(); tick();
        chk("bp_out_count", 0, 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            chk("bp_out0", 0, 32'(out_log[0]), 32'h1);
            chk("bp_out1", 0, 32'(out_log[1]), 32'h2);
            chk("bp_out2", 0, 32'(out_log[2]), 32'h3);
        end

        // Reset with both stages full.
        ready_in = 1'b0; valid_in = 1'b1;
        sum_in = 16'h0005; tick();
        sum_in = 16'h0006; tick();
        valid_in = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
            chk("mrst_valid_o", i, 32'(w_valid[i]), 32'd0);
            chk("mrst_result_o", i, 32'(w_res[i]), 32'd0);
            chk("mrst_ready_o", i, 32'(w_ready[i]), 32'd1);
        end
        out_log.delete();
        ready_in = 1'b1;
        tick(); tick(); tick(); tick();
        chk("mrst_no_stale", 0, 32'(out_log.size()), 32'd0);

        // Streaming 100 back-to-back beats: no bubbles.
        snap = n_out;
        ready_in = 1'b1; valid_in = 1'b1;
        for (int k = 0; k < 100; k++) begin
            sum_in = DW'($urandom); carry_in = DW'($urandom);
            tick();
        end
        valid_in = 1'b0;
        tick(); tick();
        chk("stream_out_count", 0, 32'(n_out - snap), 32'd100);

        // Random handshake, 10k beats.
        acc0 = n_acc; cyc = 0;
        while ((n_acc - acc0) < 10000 && cyc < 60000) begin
            valid_in = 1'($urandom_range(0, 1));
            ready_in = 1'($urandom_range(0, 1));
            sum_in = DW'($urandom); carry_in = DW'($urandom);
            tick();
            cyc++;
        end
        chk("rand_accepted", 0, 32'(n_acc - acc0), 32'd10000);
        valid_in = 1'b0; ready_in = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("drain_empty", 0, 32'(q_val.size()), 32'd0);
        chk("no_loss_total", 0, 32'(n_out), 32'(n_acc - n_drop));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
